weight_load_ctrl: RTL and testbench

Sequencer for the 16-entry, 8-bit weight memory feeding the 2x2 systolic array. It accepts two host commands. A fetch command streams a given number of bytes from the host into consecutive weight-memory entries. A load command pulses the memory's 4-weight parallel read at a tile address. Every accepted command is followed by a one-cycle done pulse; illegal or colliding commands raise an error pulse and are dropped.

---
 rtl/tpu_pkg.sv | 21 ++
 rtl/wl_cmd_check.sv | 43 ++++
 rtl/weight_load_ctrl.sv | 130 +++++++++++++
 tb/tb_weight_load_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU weight-path blocks.
`default_nettype none

package tpu_pkg;

  localparam int WMEM_DEPTH  = 16;
  localparam int WMEM_TILE   = 4;
  localparam int WMEM_ADDR_W = 13;
  localparam int DATA_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/wl_cmd_check.sv
// Legality and collision decode for weight_load_ctrl host commands.
`default_nettype none

module wl_cmd_check
  import tpu_pkg::*;
#(
  parameter int DEPTH  = WMEM_DEPTH,
  parameter int TILE   = WMEM_TILE,
  parameter int ADDR_W = WMEM_ADDR_W
) (
  input  logic              idle,
  input  logic              cmd_fetch,
  input  logic [4:0]        fetch_len,
  input  logic              cmd_load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              take_fetch,
  output logic              take_load,
  output logic              reject
);

  localparam logic [4:0]      LEN_MAX  = 5'(DEPTH);
  localparam logic [ADDR_W:0] TILE_EXT = (ADDR_W + 1)'(TILE);
  localparam logic [ADDR_W:0] ADDR_TOP = (ADDR_W + 1)'(DEPTH);

  logic fetch_ok;
  logic load_ok;

  // Extra bit on the sum keeps large addresses from wrapping into range.
  assign fetch_ok = (fetch_len <= LEN_MAX);
  assign load_ok  = (({1'b0, load_addr} + TILE_EXT) <= ADDR_TOP);

  // Fetch wins a collision; the load is dropped and flagged.
  assign take_fetch = idle && cmd_fetch && fetch_ok;
  assign take_load  = idle && cmd_load && !cmd_fetch && load_ok;

  assign reject = (!idle && (cmd_fetch || cmd_load))
               || (idle && cmd_fetch && !fetch_ok)
               || (idle && cmd_fetch && cmd_load)
               || (idle && cmd_load && !cmd_fetch && !load_ok);

endmodule

`default_nettype wire

// File: rtl/weight_load_ctrl.sv
// Host-to-weight-memory fetch sequencer and tile-load pulser for the 2x2 array.
`default_nettype none

module weight_load_ctrl
  import tpu_pkg::*;
#(
  parameter int DATA_W = tpu_pkg::DATA_W,
  parameter int DEPTH  = WMEM_DEPTH,
  parameter int TILE   = WMEM_TILE,
  parameter int ADDR_W = WMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_fetch,
  input  logic [4:0]        fetch_len,
  input  logic              cmd_load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              mem_we,
  output logic [3:0]        mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              done,
  output logic              error
);

  ctrl_state_t state;
  ctrl_state_t state_nx;

  logic [4:0] len;
  logic [4:0] ptr;
  logic [4:0] ptr_inc;
  logic       accept;
  logic       take_fetch;
  logic       take_load;
  logic       reject;

  wl_cmd_check #(
    .DEPTH  (DEPTH),
    .TILE   (TILE),
    .ADDR_W (ADDR_W)
  ) u_cmd_check (
    .idle       (state == ST_IDLE),
    .cmd_fetch  (cmd_fetch),
    .fetch_len  (fetch_len),
    .cmd_load   (cmd_load),
    .load_addr  (load_addr),
    .take_fetch (take_fetch),
    .take_load  (take_load),
    .reject     (reject)
  );

  assign host_ready = (state == ST_FETCH);
  assign busy       = (state != ST_IDLE);
  assign accept     = host_ready && host_valid;
  assign ptr_inc    = ptr + 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (take_fetch) begin
          state_nx = (fetch_len == 5'd0) ? ST_DONE : ST_FETCH;
        end else if (take_load) begin
          state_nx = ST_LOAD;
        end
      end
      ST_FETCH: begin
        if (accept && (ptr_inc == len)) begin
          state_nx = ST_DONE;
        end
      end
      ST_LOAD:   state_nx = ST_SETTLE;
      ST_SETTLE: state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Strobes are registered off the next-state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len       <= '0;
      ptr       <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_load  <= 1'b0;
      mem_addr  <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (take_fetch) begin
        len <= fetch_len;
        ptr <= '0;
      end else if (accept) begin
        ptr <= ptr_inc;
      end

      mem_we <= accept;
      if (accept) begin
        mem_waddr <= ptr[3:0];
        mem_wdata <= host_data;
      end

      mem_load <= take_load;
      if (take_load) begin
        mem_addr <= load_addr;
      end

      done  <= (state_nx == ST_DONE);
      error <= reject;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_weight_load_ctrl.sv
// Directed bench for weight_load_ctrl with a behavioural 16x8 weight memory.
`default_nettype none

module tb_weight_load_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_fetch;
  logic [4:0]  fetch_len;
  logic        cmd_load;
  logic [12:0] load_addr;
  logic        host_valid;
  logic [7:0]  host_data;
  logic        host_ready;
  logic        mem_we;
  logic [3:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic        mem_load;
  logic [12:0] mem_addr;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int overlap = 0;
  int we0;
  int n;

  logic [7:0] wmem [16];
  logic [7:0] w1, w2, w3, w4;

  logic [7:0] f4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic       sv [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] sd [5] = '{8'hA1, 8'hEE, 8'hEE, 8'hA2, 8'hA3};

  weight_load_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_fetch  (cmd_fetch),
    .fetch_len  (fetch_len),
    .cmd_load   (cmd_load),
    .load_addr  (load_addr),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_load   (mem_load),
    .mem_addr   (mem_addr),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      wmem[mem_waddr] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (mem_load) begin
      w1 <= wmem[mem_addr[3:0]];
      w2 <= wmem[mem_addr[3:0] + 4'd1];
      w3 <= wmem[mem_addr[3:0] + 4'd2];
      w4 <= wmem[mem_addr[3:0] + 4'd3];
    end
    if (mem_we && mem_load) overlap <= overlap + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    cmd_fetch = 0; fetch_len = 0; cmd_load = 0; load_addr = 0;
    host_valid = 0; host_data = 0;
    cyc(); cyc();

    chk("rst_host_ready", 32'(host_ready), 0);
    chk("rst_mem_we",     32'(mem_we), 0);
    chk("rst_mem_waddr",  32'(mem_waddr), 0);
    chk("rst_mem_wdata",  32'(mem_wdata), 0);
    chk("rst_mem_load",   32'(mem_load), 0);
    chk("rst_mem_addr",   32'(mem_addr), 0);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_done",       32'(done), 0);
    chk("rst_error",      32'(error), 0);
    reset = 0;
    cyc();

    // Fetch 4 bytes back to back
    cmd_fetch = 1; fetch_len = 4;
    cyc();
    cmd_fetch = 0;
    chk("f4_busy", 32'(busy), 1);
    chk("f4_ready", 32'(host_ready), 1);
    for (int i = 0; i < 4; i++) begin
      host_valid = 1; host_data = f4[i];
      cyc();
      chk("f4_we",    32'(mem_we), 1);
      chk("f4_waddr", 32'(mem_waddr), 32'(i));
      chk("f4_wdata", 32'(mem_wdata), 32'(f4[i]));
      chk("f4_done",  32'(done), (i == 3) ? 1 : 0);
      chk("f4_busy_run", 32'(busy), 1);
    end
    host_valid = 0;
    chk("f4_ready_drop", 32'(host_ready), 0);
    cyc();
    chk("f4_idle", 32'(busy), 0);
    chk("f4_done_clr", 32'(done), 0);
    chk("f4_we_clr", 32'(mem_we), 0);

    // Fetch 3 with host stalls
    we0 = we_cnt; n = 0;
    cmd_fetch = 1; fetch_len = 3;
    cyc();
    cmd_fetch = 0;
    for (int i = 0; i < 5; i++) begin
      host_valid = sv[i]; host_data = sd[i];
      cyc();
      chk("st_we", 32'(mem_we), 32'(sv[i]));
      if (sv[i]) begin
        chk("st_waddr", 32'(mem_waddr), 32'(n));
        chk("st_wdata", 32'(mem_wdata), 32'(sd[i]));
        n++;
      end
      chk("st_done", 32'(done), (i == 4) ? 1 : 0);
    end
    host_valid = 0;
    cyc();
    chk("st_writes", 32'(we_cnt - we0), 3);
    chk("st_idle", 32'(busy), 0);

    // Preload 0x01..0x10 with a full-depth fetch
    cmd_fetch = 1; fetch_len = 16;
    cyc();
    cmd_fetch = 0;
    for (int i = 0; i < 16; i++) begin
      host_valid = 1; host_data = 8'(i + 1);
      cyc();
    end
    chk("pl_done", 32'(done), 1);
    chk("pl_waddr", 32'(mem_waddr), 15);
    chk("pl_wdata", 32'(mem_wdata), 32'h10);
    host_valid = 0;
    cyc();

    // Load tile at address 4
    cmd_load = 1; load_addr = 4;
    cyc();
    cmd_load = 0;
    chk("ld_load", 32'(mem_load), 1);
    chk("ld_addr", 32'(mem_addr), 4);
    chk("ld_busy", 32'(busy), 1);
    chk("ld_done_early", 32'(done), 0);
    cyc();
    chk("ld_load_one", 32'(mem_load), 0);
    chk("ld_w1", 32'(w1), 32'h05);
    chk("ld_w2", 32'(w2), 32'h06);
    chk("ld_w3", 32'(w3), 32'h07);
    chk("ld_w4", 32'(w4), 32'h08);
    chk("ld_done_settle", 32'(done), 0);
    cyc();
    chk("ld_done", 32'(done), 1);
    cyc();
    chk("ld_idle", 32'(busy), 0);

    // Highest legal tile address
    cmd_load = 1; load_addr = 12;
    cyc();
    cmd_load = 0;
    chk("ld12_load", 32'(mem_load), 1);
    chk("ld12_err", 32'(error), 0);
    cyc();
    chk("ld12_w1", 32'(w1), 32'h0D);
    chk("ld12_w4", 32'(w4), 32'h10);
    cyc(); cyc();

    // Out-of-range tile address
    cmd_load = 1; load_addr = 13;
    cyc();
    cmd_load = 0;
    chk("ld13_err", 32'(error), 1);
    chk("ld13_load", 32'(mem_load), 0);
    chk("ld13_busy", 32'(busy), 0);
    cyc();
    chk("ld13_err_pulse", 32'(error), 0);

    // Oversized fetch
    cmd_fetch = 1; fetch_len = 17;
    cyc();
    cmd_fetch = 0;
    chk("f17_err", 32'(error), 1);
    chk("f17_busy", 32'(busy), 0);
    cyc();

    // Load issued while fetching
    cmd_fetch = 1; fetch_len = 2;
    cyc();
    cmd_fetch = 0;
    cmd_load = 1; load_addr = 0; host_valid = 1; host_data = 8'hB1;
    cyc();
    cmd_load = 0;
    chk("bz_err", 32'(error), 1);
    chk("bz_we", 32'(mem_we), 1);
    chk("bz_waddr", 32'(mem_waddr), 0);
    chk("bz_load", 32'(mem_load), 0);
    host_data = 8'hB2;
    cyc();
    chk("bz_waddr2", 32'(mem_waddr), 1);
    chk("bz_wdata2", 32'(mem_wdata), 32'hB2);
    chk("bz_done", 32'(done), 1);
    chk("bz_err_clr", 32'(error), 0);
    host_valid = 0;
    cyc();

    // Simultaneous fetch and load
    cmd_fetch = 1; fetch_len = 1; cmd_load = 1; load_addr = 0;
    cyc();
    cmd_fetch = 0; cmd_load = 0;
    chk("col_err", 32'(error), 1);
    chk("col_fetch", 32'(host_ready), 1);
    chk("col_load", 32'(mem_load), 0);
    host_valid = 1; host_data = 8'hC1;
    cyc();
    chk("col_done", 32'(done), 1);
    chk("col_we", 32'(mem_we), 1);
    chk("col_waddr", 32'(mem_waddr), 0);
    host_valid = 0;
    cyc();

    // Zero-length fetch
    we0 = we_cnt;
    cmd_fetch = 1; fetch_len = 0;
    cyc();
    cmd_fetch = 0;
    chk("z_done", 32'(done), 1);
    chk("z_we", 32'(mem_we), 0);
    chk("z_err", 32'(error), 0);
    cyc();
    chk("z_idle", 32'(busy), 0);
    chk("z_done_clr", 32'(done), 0);
    chk("z_writes", 32'(we_cnt - we0), 0);

    // Reset in the middle of a fetch
    cmd_fetch = 1; fetch_len = 4;
    cyc();
    cmd_fetch = 0;
    host_valid = 1; host_data = 8'hD1;
    cyc();
    host_data = 8'hD2;
    cyc();
    chk("mr_we", 32'(mem_we), 1);
    chk("mr_waddr", 32'(mem_waddr), 1);
    reset = 1;
    #1;
    chk("mr_async_we", 32'(mem_we), 0);
    chk("mr_async_busy", 32'(busy), 0);
    chk("mr_async_waddr", 32'(mem_waddr), 0);
    cyc();
    chk("mr_busy", 32'(busy), 0);
    chk("mr_ready", 32'(host_ready), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_err", 32'(error), 0);
    reset = 0; host_valid = 0;
    cyc();
    cmd_fetch = 1; fetch_len = 1;
    cyc();
    cmd_fetch = 0;
    host_valid = 1; host_data = 8'hE1;
    cyc();
    chk("rs_waddr", 32'(mem_waddr), 0);
    chk("rs_wdata", 32'(mem_wdata), 32'hE1);
    chk("rs_done", 32'(done), 1);
    host_valid = 0;
    cyc();
    chk("rs_mem_kept", 32'(wmem[2]), 32'h03);
    chk("no_we_load_overlap", 32'(overlap), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
